// File: rtl/store_commit_drain.sv
// Commit-FIFO drain for retired stores: captures stores from the store queue, writes them
// to data memory in retire order over req/gnt/ack, then frees the store queue entry.
// Optional statistics counters are enabled by defining STORE_DRAIN_STATS_EN.
module store_commit_drain #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CQ_DEPTH   = 4,
  localparam int IDW       = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  retire_store_valid,
  input  logic [IDW-1:0]        retire_store_id,
  output logic [IDW-1:0]        sq_rd_id,
  input  logic [ADDR_WIDTH-1:0] sq_rd_addr,
  input  logic [DATA_WIDTH-1:0] sq_rd_data,
  input  logic [1:0]            sq_rd_size,
  output logic                  cq_full,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_ack,
  output logic                  sq_free_valid,
  output logic [IDW-1:0]        sq_free_id,
  output logic                  drain_empty,
  output logic                  cq_overflow
`ifdef STORE_DRAIN_STATS_EN
  ,output logic [31:0]          stat_stores
  ,output logic [31:0]          stat_stall_cyc
`endif
);

  localparam int PW = $clog2(CQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(CQ_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FREE} state_t;

  state_t state, state_next;

  logic [IDW-1:0]        q_id   [CQ_DEPTH];
  logic [ADDR_WIDTH-1:0] q_addr [CQ_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [CQ_DEPTH];
  logic [1:0]            q_size [CQ_DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop;

  logic [IDW-1:0]        head_id;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic [1:0]            head_size;
  logic [1:0]            head_o;
  logic [3:0]            lane_strb;
  logic [DATA_WIDTH-1:0] lane_data;

  assign sq_rd_id = retire_store_id;
  assign push     = retire_store_valid && (count != FULL_CNT);

  assign head_id   = q_id[rd_ptr];
  assign head_addr = q_addr[rd_ptr];
  assign head_data = q_data[rd_ptr];
  assign head_size = q_size[rd_ptr];

  // Payload storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]   <= retire_store_id;
      q_addr[wr_ptr] <= sq_rd_addr;
      q_data[wr_ptr] <= sq_rd_data;
      q_size[wr_ptr] <= sq_rd_size;
    end
  end

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cq_full     <= 1'b0;
      cq_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_next;
      cq_full <= (count_next == FULL_CNT);
      if (retire_store_valid && (count == FULL_CNT)) cq_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (count != '0) state_next = S_REQ;
      S_REQ:   if (mem_gnt) state_next = mem_ack ? S_FREE : S_WAIT;
      S_WAIT:  if (mem_ack) state_next = S_FREE;
      S_FREE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Misaligned halves/words and the reserved size go out with an all-zero strobe.
  always_comb begin
    head_o    = head_addr[1:0];
    lane_strb = '0;
    lane_data = head_data;
    case (head_size)
      2'd0: begin
        lane_strb = 4'b0001 << head_o;
        lane_data = {4{head_data[7:0]}};
      end
      2'd1: begin
        if (!head_o[0]) lane_strb = 4'b0011 << head_o;
        lane_data = {2{head_data[15:0]}};
      end
      2'd2:    if (head_o == 2'd0) lane_strb = 4'b1111;
      default: lane_strb = '0;
    endcase
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wstrb     = '0;
    sq_free_valid = 1'b0;
    sq_free_id    = '0;
    pop           = 1'b0;
    case (state)
      S_REQ: begin
        mem_req   = 1'b1;
        mem_addr  = {head_addr[ADDR_WIDTH-1:2], 2'b00};
        mem_wdata = lane_data;
        mem_wstrb = lane_strb;
      end
      S_FREE: begin
        sq_free_valid = 1'b1;
        sq_free_id    = head_id;
        pop           = 1'b1;
      end
      default: ;
    endcase
    drain_empty = (count == '0) && (state == S_IDLE);
  end

`ifdef STORE_DRAIN_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stores    <= '0;
      stat_stall_cyc <= '0;
    end else begin
      if (state == S_FREE)             stat_stores    <= stat_stores + 32'd1;
      if (state == S_REQ && !mem_gnt)  stat_stall_cyc <= stat_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_store_commit_drain.sv
// Self-checking bench for store_commit_drain: directed scenarios plus randomized stores
// compared against a queue-based reference of retire order and lane formatting.
module tb_store_commit_drain;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        retire_store_valid = 1'b0;
  logic [3:0]  retire_store_id = '0;
  logic [3:0]  sq_rd_id;
  logic [31:0] sq_rd_addr = '0;
  logic [31:0] sq_rd_data = '0;
  logic [1:0]  sq_rd_size = '0;
  logic        cq_full;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_ack = 1'b0;
  logic        sq_free_valid;
  logic [3:0]  sq_free_id;
  logic        drain_empty;
  logic        cq_overflow;

  int checks = 0;
  int failures = 0;
  int mode = 3;  // memory responder: 0 never grants, 1 gnt+ack at once, 2 random, 3 manual

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
  } st_t;

  st_t         exp_q[$];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_wdata[$];
  logic [3:0]  obs_wstrb[$];
  logic [3:0]  obs_free[$];

  store_commit_drain #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .FIFO_DEPTH(16),
    .CQ_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .retire_store_valid(retire_store_valid),
    .retire_store_id(retire_store_id),
    .sq_rd_id(sq_rd_id),
    .sq_rd_addr(sq_rd_addr),
    .sq_rd_data(sq_rd_data),
    .sq_rd_size(sq_rd_size),
    .cq_full(cq_full),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt),
    .mem_ack(mem_ack),
    .sq_free_valid(sq_free_valid),
    .sq_free_id(sq_free_id),
    .drain_empty(drain_empty),
    .cq_overflow(cq_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-lane reference: strobe and replicated data from plain arithmetic.
  function automatic logic [3:0] exp_wstrb(logic [31:0] a, logic [1:0] s);
    int o;
    o = int'(a % 4);
    case (s)
      2'd0:    return 4'(1 << o);
      2'd1:    return (o % 2 == 0) ? 4'(3 << o) : 4'h0;
      2'd2:    return (o == 0) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(logic [31:0] d, logic [1:0] s);
    case (s)
      2'd0:    return (d & 32'hFF) * 32'h0101_0101;
      2'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  initial begin
    bit pending;
    pending = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) pending = 1'b0;
      case (mode)
        0: begin mem_gnt = 1'b0; mem_ack = 1'b0; end
        1: begin mem_gnt = mem_req; mem_ack = mem_req; end
        2: begin
          mem_gnt = 1'b0;
          mem_ack = 1'b0;
          if (pending) begin
            mem_ack = 1'($urandom % 2);
            if (mem_ack) pending = 1'b0;
          end else if (mem_req) begin
            mem_gnt = 1'($urandom % 2);
            if (mem_gnt) begin
              mem_ack = 1'($urandom % 2);
              if (!mem_ack) pending = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_req && mem_gnt) begin
        obs_addr.push_back(mem_addr);
        obs_wdata.push_back(mem_wdata);
        obs_wstrb.push_back(mem_wstrb);
      end
      if (sq_free_valid) obs_free.push_back(sq_free_id);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s);
    retire_store_valid = 1'b1;
    retire_store_id    = id;
    sq_rd_addr         = a;
    sq_rd_data         = d;
    sq_rd_size         = s;
    step();
    retire_store_valid = 1'b0;
  endtask

  task automatic apply_reset();
    mode = 3;
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    retire_store_valid = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    exp_q.delete();
    obs_addr.delete();
    obs_wdata.delete();
    obs_wstrb.delete();
    obs_free.delete();
  endtask

  task automatic test_reset();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (drain_empty !== 1'b1 || mem_req !== 1'b0 || cq_full !== 1'b0 ||
        cq_overflow !== 1'b0 || sq_free_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: empty=%b req=%b full=%b ovf=%b free=%b, required 1 0 0 0 0",
               drain_empty, mem_req, cq_full, cq_overflow, sq_free_valid);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (drain_empty !== 1'b1 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: empty=%b req=%b, required 1 0", drain_empty, mem_req);
    end
  endtask

  task automatic test_word_store();
    apply_reset();
    mode = 1;
    push(4'd5, 32'h100, 32'hDEAD_BEEF, 2'd2);
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("FAIL word_req_early: mem_req=%b, required 0", mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1 || mem_wstrb !== 4'hF || mem_addr !== 32'h100 ||
        mem_wdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL word_req: req=%b strb=%h addr=%h data=%h, required 1 f 00000100 deadbeef",
               mem_req, mem_wstrb, mem_addr, mem_wdata);
    end
    step();
    checks++;
    if (sq_free_valid !== 1'b1 || sq_free_id !== 4'd5) begin
      failures++;
      $display("FAIL word_free: valid=%b id=%0d, required 1 5", sq_free_valid, sq_free_id);
    end
    step();
    checks++;
    if (sq_free_valid !== 1'b0 || drain_empty !== 1'b1) begin
      failures++;
      $display("FAIL word_done: free=%b empty=%b, required 0 1", sq_free_valid, drain_empty);
    end
  endtask

  task automatic test_lane_format();
    logic [1:0]  sz[4] = '{2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] ad[4] = '{32'h203, 32'h302, 32'h101, 32'h40C};
    logic [31:0] da[4] = '{32'h0000_00AB, 32'h0000_1234, 32'hCAFE_F00D, 32'h1357_9BDF};
    logic [31:0] ea[4] = '{32'h200, 32'h300, 32'h100, 32'h40C};
    logic [3:0]  es[4] = '{4'b1000, 4'b1100, 4'b0000, 4'b1111};
    logic [31:0] ed[4] = '{32'hABAB_ABAB, 32'h1234_1234, 32'h0, 32'h1357_9BDF};
    apply_reset();
    mode = 1;
    for (int i = 0; i < 4; i++) begin
      push(4'(i + 8), ad[i], da[i], sz[i]);
      step();
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== ea[i] || mem_wstrb !== es[i] ||
          (es[i] != 4'h0 && mem_wdata !== ed[i])) begin
        failures++;
        $display("FAIL lane_%0d: req=%b addr=%h strb=%b data=%h, required 1 %h %b %h",
                 i, mem_req, mem_addr, mem_wstrb, mem_wdata, ea[i], es[i], ed[i]);
      end
      step();
      checks++;
      if (sq_free_valid !== 1'b1 || sq_free_id !== 4'(i + 8)) begin
        failures++;
        $display("FAIL lane_free_%0d: valid=%b id=%0d, required 1 %0d",
                 i, sq_free_valid, sq_free_id, i + 8);
      end
      step();
    end
  endtask

  task automatic test_full_overflow();
    int k;
    apply_reset();
    mode = 0;
    for (int i = 1; i <= 5; i++) begin
      push(4'(i), 32'h1000 + 32'(4 * i), 32'(i * 32'h1111), 2'd2);
      checks++;
      if (cq_full !== (i >= 4) || cq_overflow !== (i == 5)) begin
        failures++;
        $display("FAIL full_after_push_%0d: full=%b ovf=%b, required %b %b",
                 i, cq_full, cq_overflow, i >= 4, i == 5);
      end
    end
    repeat (6) step();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h1004 || mem_wdata !== 32'h1111) begin
      failures++;
      $display("FAIL stall_hold: req=%b addr=%h data=%h, required 1 00001004 00001111",
               mem_req, mem_addr, mem_wdata);
    end
    mode = 1;
    k = 0;
    while (!drain_empty && k < 200) begin step(); k++; end
    checks++;
    if (obs_free.size() != 4) begin
      failures++;
      $display("FAIL full_drain_count: frees=%0d, required 4", obs_free.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_free[i] !== 4'(i + 1)) begin
          failures++;
          $display("FAIL full_drain_order_%0d: id=%0d, required %0d", i, obs_free[i], i + 1);
        end
      end
    end
    checks++;
    if (cq_overflow !== 1'b1 || cq_full !== 1'b0) begin
      failures++;
      $display("FAIL overflow_sticky: ovf=%b full=%b, required 1 0", cq_overflow, cq_full);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ids[$];
    int k;
    int n;
    apply_reset();
    push(4'd10, 32'h10, 32'hA, 2'd2);
    push(4'd11, 32'h14, 32'hB, 2'd2);
    k = 0;
    while (!mem_req && k < 10) begin step(); k++; end
    mem_gnt = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_ack = 1'b0;
    checks++;
    if (sq_free_valid !== 1'b1 || sq_free_id !== 4'd10) begin
      failures++;
      $display("FAIL b2b_first_free: valid=%b id=%0d, required 1 10", sq_free_valid, sq_free_id);
    end
    push(4'd12, 32'h18, 32'hC, 2'd2);
    checks++;
    if (cq_full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_push_pop: full=%b, required 0", cq_full);
    end
    push(4'd13, 32'h1C, 32'hD, 2'd2);
    checks++;
    if (cq_full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_count3: full=%b, required 0", cq_full);
    end
    push(4'd14, 32'h20, 32'hE, 2'd2);
    checks++;
    if (cq_full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_count4: full=%b, required 1", cq_full);
    end
    exp_ids = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14};
    mode = 1;
    n = 0;
    k = 0;
    while (n < 10 && k < 400) begin
      if (!cq_full) begin
        push(4'(n), 32'h100 + 32'(4 * n), 32'(n), 2'd2);
        exp_ids.push_back(4'(n));
        n++;
      end else begin
        step();
      end
      k++;
    end
    k = 0;
    while (!drain_empty && k < 400) begin step(); k++; end
    checks++;
    if (obs_free.size() != exp_ids.size() || cq_overflow !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: frees=%0d ovf=%b, required %0d 0",
               obs_free.size(), cq_overflow, exp_ids.size());
    end else begin
      for (int i = 0; i < exp_ids.size(); i++) begin
        checks++;
        if (obs_free[i] !== exp_ids[i]) begin
          failures++;
          $display("FAIL b2b_order_%0d: id=%0d, required %0d", i, obs_free[i], exp_ids[i]);
        end
      end
    end
  endtask

  task automatic test_reset_in_wait();
    int k;
    apply_reset();
    push(4'd7, 32'h700, 32'h7777, 2'd2);
    k = 0;
    while (!mem_req && k < 10) begin step(); k++; end
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || sq_free_valid !== 1'b0 || drain_empty !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: req=%b free=%b empty=%b, required 0 0 0",
               mem_req, sq_free_valid, drain_empty);
    end
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (drain_empty !== 1'b1 || mem_req !== 1'b0 || sq_free_valid !== 1'b0 || cq_full !== 1'b0) begin
      failures++;
      $display("FAIL wait_reset: empty=%b req=%b free=%b full=%b, required 1 0 0 0",
               drain_empty, mem_req, sq_free_valid, cq_full);
    end
    step();
    rst_n = 1'b1;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sq_free_valid !== 1'b0 || mem_req !== 1'b0 || drain_empty !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_%0d: free=%b req=%b empty=%b, required 0 0 1",
                 i, sq_free_valid, mem_req, drain_empty);
      end
      step();
    end
  endtask

  task automatic test_random();
    st_t e;
    int k;
    logic [3:0] s;
    apply_reset();
    mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      k = 0;
      while (cq_full && k < 100) begin step(); k++; end
      e.id   = 4'($urandom % 16);
      e.addr = $urandom;
      e.data = $urandom;
      e.size = 2'($urandom % 4);
      push(e.id, e.addr, e.data, e.size);
      exp_q.push_back(e);
    end
    k = 0;
    while (!drain_empty && k < 2000) begin step(); k++; end
    checks++;
    if (obs_free.size() != exp_q.size() || obs_addr.size() != exp_q.size() ||
        cq_overflow !== 1'b0) begin
      failures++;
      $display("FAIL rand_counts: frees=%0d writes=%0d ovf=%b, required %0d %0d 0",
               obs_free.size(), obs_addr.size(), cq_overflow, exp_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        s = exp_wstrb(exp_q[i].addr, exp_q[i].size);
        checks++;
        if (obs_free[i] !== exp_q[i].id || obs_addr[i] !== (exp_q[i].addr & ~32'h3) ||
            obs_wstrb[i] !== s ||
            (s != 4'h0 && obs_wdata[i] !== exp_wdata(exp_q[i].data, exp_q[i].size))) begin
          failures++;
          $display("FAIL rand_store_%0d: id=%0d addr=%h strb=%b data=%h, required %0d %h %b %h",
                   i, obs_free[i], obs_addr[i], obs_wstrb[i], obs_wdata[i], exp_q[i].id,
                   exp_q[i].addr & ~32'h3, s, exp_wdata(exp_q[i].data, exp_q[i].size));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_lane_format();
    test_full_overflow();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
